param_reg_file: RTL and testbench

//  Parametrised successor of the 8-bit 4R/4T register file. Holds NREG general

---
 rtl/param_reg_file_if.sv | 27 ++
 rtl/param_reg_file.sv | 83 ++++++++
 tb/tb_param_reg_file.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/param_reg_file_if.sv
// rtl/param_reg_file_if.sv - control/data bundle between the control unit and param_reg_file
interface param_reg_file_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int NTMP  = 4,
    parameter int SELW  = 4
);
    logic [1:0]       fun_sel;
    logic [NREG-1:0]  r_sel;
    logic [NTMP-1:0]  t_sel;
    logic [WIDTH-1:0] i;
    logic [SELW-1:0]  o1_sel;
    logic [SELW-1:0]  o2_sel;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic             wrap;

    modport master (
        output fun_sel, r_sel, t_sel, i, o1_sel, o2_sel,
        input  o1, o2, wrap
    );

    modport slave (
        input  fun_sel, r_sel, t_sel, i, o1_sel, o2_sel,
        output o1, o2, wrap
    );
endinterface

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - NREG general + NTMP temporary registers, shared funsel, two mux read ports
// Optional RF_SATURATE_EN: inc/dec saturate at the limits instead of wrapping.
module param_reg_file #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int NTMP  = 4,
    parameter int SELW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    param_reg_file_if.slave    bus
);
    localparam int NTOT = NREG + NTMP;

    typedef logic [WIDTH-1:0] word_t;
    localparam word_t ONE = word_t'(1);

    // Flat storage: index 0..NTMP-1 holds T1..Tn, NTMP.. holds R1..Rn (matches read-select map)
    word_t           regs_q [NTOT];
    word_t           regs_d [NTOT];
    logic            wrap_q, wrap_d;
    logic [NTOT-1:0] en;
    word_t           o1_mux, o2_mux;

    always_comb begin
        en = '0;
        for (int k = 0; k < NTMP; k++) en[k] = bus.t_sel[NTMP-1-k];
        for (int j = 0; j < NREG; j++) en[NTMP+j] = bus.r_sel[NREG-1-j];
    end

    always_comb begin
        wrap_d = 1'b0;
        for (int k = 0; k < NTOT; k++) begin
            regs_d[k] = regs_q[k];
            if (en[k]) begin
                case (bus.fun_sel)
                    2'b00: begin
                        if (regs_q[k] == '0) wrap_d = 1'b1;
`ifdef RF_SATURATE_EN
                        if (regs_q[k] != '0) regs_d[k] = regs_q[k] - ONE;
`else
                        regs_d[k] = regs_q[k] - ONE;
`endif
                    end
                    2'b01: begin
                        if (regs_q[k] == '1) wrap_d = 1'b1;
`ifdef RF_SATURATE_EN
                        if (regs_q[k] != '1) regs_d[k] = regs_q[k] + ONE;
`else
                        regs_d[k] = regs_q[k] + ONE;
`endif
                    end
                    2'b10:   regs_d[k] = bus.i;
                    default: regs_d[k] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTOT; k++) regs_q[k] <= '0;
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NTOT; k++) regs_q[k] <= regs_d[k];
            wrap_q <= wrap_d;
        end
    end

    // Unmapped selects fall through to zero
    always_comb begin
        o1_mux = '0;
        o2_mux = '0;
        for (int k = 0; k < NTOT; k++) begin
            if (bus.o1_sel == SELW'(k)) o1_mux = regs_q[k];
            if (bus.o2_sel == SELW'(k)) o2_mux = regs_q[k];
        end
    end

    assign bus.o1   = o1_mux;
    assign bus.o2   = o2_mux;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - self-checking bench for param_reg_file (default 8-bit, 4R/4T)
`timescale 1ns/100ps
module tb_param_reg_file;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    param_reg_file_if #(.WIDTH(8), .NREG(4), .NTMP(4), .SELW(4)) bus ();

    param_reg_file #(.WIDTH(8), .NREG(4), .NTMP(4), .SELW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fun;
        logic [3:0] rs;
        logic [3:0] ts;
        logic [7:0] d;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ew;
    } vec_t;

    typedef struct packed {
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ew;
    } exp_t;

`ifdef RF_SATURATE_EN
    localparam logic [7:0] T3_INC = 8'hFF;
    localparam logic [7:0] R2_DEC = 8'h00;
    localparam logic [7:0] T2_DEC = 8'h00;
`else
    localparam logic [7:0] T3_INC = 8'h00;
    localparam logic [7:0] R2_DEC = 8'hFF;
    localparam logic [7:0] T2_DEC = 8'hFF;
`endif

    vec_t vecs [13];
    exp_t sb [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hold_val(input int s);
        return (s == 7) ? 8'h5A : 8'h00;
    endfunction

    initial begin
        exp_t e;
        tests = 0;
        fails = 0;

        //          fun    rs       ts       d      s1  s2  e1     e2      ew
        vecs[0]  = '{2'b10, 4'b1000, 4'b0000, 8'hA5, 4,  5,  8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{2'b10, 4'b0000, 4'b0010, 8'hFF, 2,  0,  8'hFF, 8'h00, 1'b0};
        vecs[2]  = '{2'b01, 4'b1000, 4'b0010, 8'h00, 4,  2,  8'hA6, T3_INC, 1'b1};
        vecs[3]  = '{2'b00, 4'b0100, 4'b0000, 8'h00, 5,  4,  R2_DEC, 8'hA6, 1'b1};
        vecs[4]  = '{2'b11, 4'b0100, 4'b0000, 8'h00, 5,  5,  8'h00, 8'h00, 1'b0};
        vecs[5]  = '{2'b10, 4'b0000, 4'b0000, 8'h3C, 4,  15, 8'hA6, 8'h00, 1'b0};
        vecs[6]  = '{2'b10, 4'b1111, 4'b1111, 8'h80, 0,  7,  8'h80, 8'h80, 1'b0};
        vecs[7]  = '{2'b00, 4'b1111, 4'b1111, 8'h00, 3,  6,  8'h7F, 8'h7F, 1'b0};
        vecs[8]  = '{2'b01, 4'b0000, 4'b0001, 8'h00, 3,  8,  8'h80, 8'h00, 1'b0};
        vecs[9]  = '{2'b10, 4'b0010, 4'b0000, 8'h11, 6,  6,  8'h11, 8'h11, 1'b0};
        vecs[10] = '{2'b11, 4'b1111, 4'b1111, 8'h00, 1,  4,  8'h00, 8'h00, 1'b0};
        vecs[11] = '{2'b00, 4'b0000, 4'b0100, 8'h00, 1,  9,  T2_DEC, 8'h00, 1'b1};
        vecs[12] = '{2'b01, 4'b0000, 4'b0000, 8'h00, 1,  1,  T2_DEC, T2_DEC, 1'b0};

        rst_n       = 1'b0;
        bus.fun_sel = 2'b00;
        bus.r_sel   = '0;
        bus.t_sel   = '0;
        bus.i       = '0;
        bus.o1_sel  = 4'd0;
        bus.o2_sel  = 4'd4;
        #2;
        chk("reset_o1", bus.o1, 8'h00);
        chk("reset_o2", bus.o2, 8'h00);
        chk("reset_wrap", {7'b0, bus.wrap}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            bus.fun_sel = vecs[k].fun;
            bus.r_sel   = vecs[k].rs;
            bus.t_sel   = vecs[k].ts;
            bus.i       = vecs[k].d;
            bus.o1_sel  = vecs[k].s1;
            bus.o2_sel  = vecs[k].s2;
            sb.push_back('{vecs[k].e1, vecs[k].e2, vecs[k].ew});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("vec%0d_o1", k), bus.o1, e.e1);
            chk($sformatf("vec%0d_o2", k), bus.o2, e.e2);
            chk($sformatf("vec%0d_wrap", k), {7'b0, bus.wrap}, {7'b0, e.ew});
        end

        // Set wrap, then assert reset mid-cycle and check without a clock edge
        @(negedge clk);
        bus.fun_sel = 2'b00;
        bus.r_sel   = 4'b1000;
        bus.t_sel   = 4'b0000;
        @(posedge clk);
        #1;
        chk("pre_reset_wrap", {7'b0, bus.wrap}, 8'h01);
        #1;
        rst_n      = 1'b0;
        bus.r_sel  = '0;
        bus.o1_sel = 4'd1;
        bus.o2_sel = 4'd4;
        #1;
        chk("async_rst_o1", bus.o1, 8'h00);
        chk("async_rst_o2", bus.o2, 8'h00);
        chk("async_rst_wrap", {7'b0, bus.wrap}, 8'h00);
        for (int s = 0; s < 16; s++) begin
            bus.o1_sel = 4'(s);
            bus.o2_sel = 4'(15 - s);
            #1;
            chk($sformatf("rst_sweep%0d", s), bus.o1 | bus.o2, 8'h00);
        end

        // First edge after release performs a normal op
        @(negedge clk);
        rst_n       = 1'b1;
        bus.fun_sel = 2'b10;
        bus.r_sel   = 4'b0001;
        bus.i       = 8'h5A;
        bus.o1_sel  = 4'd7;
        bus.o2_sel  = 4'd4;
        @(posedge clk);
        #1;
        chk("post_rst_load_r4", bus.o1, 8'h5A);
        chk("post_rst_r1", bus.o2, 8'h00);

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.r_sel   = '0;
            bus.t_sel   = '0;
            bus.fun_sel = 2'($urandom_range(0, 3));
            bus.i       = 8'($urandom);
            bus.o1_sel  = 4'(c);
            bus.o2_sel  = 4'(15 - c);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_o1", c), bus.o1, hold_val(c));
            chk($sformatf("hold%0d_o2", c), bus.o2, hold_val(15 - c));
            chk($sformatf("hold%0d_wrap", c), {7'b0, bus.wrap}, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
